// File: rtl/tracker_pkg.sv
// tracker_pkg
// Shared definitions for the light tracker slice:
//   - state_t   : FSM state encoding, also exported on state_dbg
//   - DIR_*     : direction request codes ({ccw, cw} bit order)
//   - timer_width(): bit width that holds the larger of two cycle counts minus one
package tracker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COMPARE  = 3'd1,
    ST_MOVE_CW  = 3'd2,
    ST_MOVE_CCW = 3'd3,
    ST_SETTLE   = 3'd4
  } state_t;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_CW   = 2'b01;
  localparam logic [1:0] DIR_CCW  = 2'b10;

  // The timer is loaded with (cycles - 1), so $clog2(max) bits are enough.
  // A single-cycle phase still needs one bit to hold the value zero.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/tracker_timer.sv
// tracker_timer
// Loadable down-counter used for the move and settle phases.
// The count stops at zero, so it never wraps while the FSM is idle.
// Ports:
//   CLK      in   system clock
//   RST      in   synchronous active-high reset (count -> 0)
//   load     in   load load_val on the next edge
//   load_val in   W-bit value to load
//   done     out  count is zero
module tracker_timer #(
  parameter int W = 17
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  // Load wins over counting; otherwise decrement until zero and hold there.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/light_tracker_fsm.sv
// light_tracker_fsm
// Single-axis sun-tracking decision stage feeding the servo driver.
// Collects a left and a right photoresistor sample, compares their
// difference against a deadband and issues a timed cw or ccw request,
// followed by a settle period with no request. Position feedback from the
// servo driver blocks or aborts moves that would pass the travel limits.
//
// Ports:
//   CLK             in   system clock
//   RST             in   synchronous active-high reset
//   adc_valid       in   one-cycle strobe, adc_ch/adc_data valid
//   adc_ch          in   0 = left LDR, 1 = right LDR
//   adc_data        in   ADC_W-bit unsigned sample
//   servo_position  in   current pulse width reported by the servo driver
//   BTN_0           out  cw request (registered)
//   BTN_1           out  ccw request (registered)
//   at_limit        out  last decision was blocked or aborted by a limit
//   busy            out  high in any state other than IDLE
//   state_dbg       out  current state encoding
//
// Build option:
//   TRACK_AVG_EN  when defined, each channel averages four samples
//                 (truncating) before it counts as captured.
module light_tracker_fsm
  import tracker_pkg::*;
#(
  parameter int ADC_W      = 12,
  parameter int DEADBAND   = 64,
  parameter int MOVE_CYC   = 50000,
  parameter int SETTLE_CYC = 100000,
  parameter int POS_MIN    = 500,
  parameter int POS_MAX    = 2500
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             adc_valid,
  input  logic             adc_ch,
  input  logic [ADC_W-1:0] adc_data,
  input  logic [31:0]      servo_position,
  output logic             BTN_0,
  output logic             BTN_1,
  output logic             at_limit,
  output logic             busy,
  output logic [2:0]       state_dbg
);

  localparam int TW = timer_width(MOVE_CYC, SETTLE_CYC);

  localparam logic [TW-1:0] MOVE_LOAD   = TW'(MOVE_CYC - 1);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYC - 1);

  localparam logic [31:0] POS_MIN_U = 32'(POS_MIN);
  localparam logic [31:0] POS_MAX_U = 32'(POS_MAX);

  localparam logic signed [ADC_W:0] DB_POS = (ADC_W + 1)'(DEADBAND);
  localparam logic signed [ADC_W:0] DB_NEG = -DB_POS;

  state_t            state;
  logic [ADC_W-1:0]  left_s;
  logic [ADC_W-1:0]  right_s;
  logic              have_l;
  logic              have_r;

  logic signed [ADC_W:0] diff;
  logic [1:0]            want_dir;
  logic                  cw_ok;
  logic                  ccw_ok;

  logic                  tmr_load;
  logic [TW-1:0]         tmr_val;
  logic                  tmr_done;

`ifdef TRACK_AVG_EN
  logic [ADC_W+1:0] acc_l;
  logic [ADC_W+1:0] acc_r;
  logic [ADC_W+1:0] sum_l;
  logic [ADC_W+1:0] sum_r;
  logic [1:0]       cnt_l;
  logic [1:0]       cnt_r;

  // Running sums including the sample currently on the bus; four 12-bit
  // samples fit in ADC_W+2 bits without overflow.
  assign sum_l = acc_l + {2'b00, adc_data};
  assign sum_r = acc_r + {2'b00, adc_data};
`endif

  // Both samples are unsigned, so widen by one bit before subtracting to
  // keep the full signed range of the difference.
  assign diff = $signed({1'b0, left_s}) - $signed({1'b0, right_s});

  // Sign of the imbalance outside the deadband; exactly +/-DEADBAND is
  // still considered balanced.
  always_comb begin
    want_dir = DIR_STOP;
    if (diff > DB_POS) begin
      want_dir = DIR_CW;
    end else if (diff < DB_NEG) begin
      want_dir = DIR_CCW;
    end
  end

  // A position sitting exactly on a limit blocks travel toward that limit.
  assign cw_ok  = (servo_position < POS_MAX_U);
  assign ccw_ok = (servo_position > POS_MIN_U);

  // Timer reloads on entry to MOVE_* (from COMPARE) and on entry to SETTLE
  // (normal end of move or limit abort). Mirrors the transitions below.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = MOVE_LOAD;
    case (state)
      ST_COMPARE: begin
        if ((want_dir == DIR_CW && cw_ok) || (want_dir == DIR_CCW && ccw_ok)) begin
          tmr_load = 1'b1;
          tmr_val  = MOVE_LOAD;
        end
      end
      ST_MOVE_CW: begin
        if (!cw_ok || tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LOAD;
        end
      end
      ST_MOVE_CCW: begin
        if (!ccw_ok || tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LOAD;
        end
      end
      default: begin
        tmr_load = 1'b0;
      end
    endcase
  end

  tracker_timer #(
    .W(TW)
  ) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Main FSM. All outputs are registered here; BTN_0 and BTN_1 are only
  // ever set on entry to their own MOVE state and cleared on leaving it,
  // so they can never be high together. Sample capture only happens in
  // IDLE, which keeps strobes during a move or settle from leaking into
  // the next decision.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      BTN_0    <= 1'b0;
      BTN_1    <= 1'b0;
      at_limit <= 1'b0;
      busy     <= 1'b0;
      left_s   <= '0;
      right_s  <= '0;
      have_l   <= 1'b0;
      have_r   <= 1'b0;
`ifdef TRACK_AVG_EN
      acc_l    <= '0;
      acc_r    <= '0;
      cnt_l    <= '0;
      cnt_r    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (have_l && have_r) begin
            state <= ST_COMPARE;
            busy  <= 1'b1;
          end
          if (adc_valid) begin
`ifdef TRACK_AVG_EN
            if (!adc_ch) begin
              if (cnt_l == 2'd3) begin
                left_s <= sum_l[ADC_W+1:2];
                have_l <= 1'b1;
                acc_l  <= '0;
                cnt_l  <= '0;
              end else begin
                acc_l  <= sum_l;
                cnt_l  <= cnt_l + 2'd1;
              end
            end else begin
              if (cnt_r == 2'd3) begin
                right_s <= sum_r[ADC_W+1:2];
                have_r  <= 1'b1;
                acc_r   <= '0;
                cnt_r   <= '0;
              end else begin
                acc_r   <= sum_r;
                cnt_r   <= cnt_r + 2'd1;
              end
            end
`else
            if (!adc_ch) begin
              left_s <= adc_data;
              have_l <= 1'b1;
            end else begin
              right_s <= adc_data;
              have_r  <= 1'b1;
            end
`endif
          end
        end

        ST_COMPARE: begin
          have_l <= 1'b0;
          have_r <= 1'b0;
`ifdef TRACK_AVG_EN
          acc_l  <= '0;
          acc_r  <= '0;
          cnt_l  <= '0;
          cnt_r  <= '0;
`endif
          if (want_dir == DIR_CW) begin
            if (cw_ok) begin
              state    <= ST_MOVE_CW;
              BTN_0    <= 1'b1;
              at_limit <= 1'b0;
            end else begin
              state    <= ST_IDLE;
              busy     <= 1'b0;
              at_limit <= 1'b1;
            end
          end else if (want_dir == DIR_CCW) begin
            if (ccw_ok) begin
              state    <= ST_MOVE_CCW;
              BTN_1    <= 1'b1;
              at_limit <= 1'b0;
            end else begin
              state    <= ST_IDLE;
              busy     <= 1'b0;
              at_limit <= 1'b1;
            end
          end else begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            at_limit <= 1'b0;
          end
        end

        // Limit abort has priority over the normal end of the move.
        ST_MOVE_CW: begin
          if (!cw_ok) begin
            state    <= ST_SETTLE;
            BTN_0    <= 1'b0;
            at_limit <= 1'b1;
          end else if (tmr_done) begin
            state <= ST_SETTLE;
            BTN_0 <= 1'b0;
          end
        end

        ST_MOVE_CCW: begin
          if (!ccw_ok) begin
            state    <= ST_SETTLE;
            BTN_1    <= 1'b0;
            at_limit <= 1'b1;
          end else if (tmr_done) begin
            state <= ST_SETTLE;
            BTN_1 <= 1'b0;
          end
        end

        ST_SETTLE: begin
          if (tmr_done) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          BTN_0 <= 1'b0;
          BTN_1 <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_light_tracker_fsm.sv
// tb_light_tracker_fsm
// Self-checking bench for light_tracker_fsm with short move/settle times.
// Expected decisions come from a small behavioural model, are queued when
// the samples are driven and popped when the DUT leaves COMPARE.
// Define TRACK_AVG_EN for both bench and RTL to exercise the averaging build.
module tb_light_tracker_fsm;

  localparam int ADC_W      = 12;
  localparam int DEADBAND   = 64;
  localparam int MOVE_CYC   = 10;
  localparam int SETTLE_CYC = 20;
  localparam int POS_MIN    = 500;
  localparam int POS_MAX    = 2500;

  localparam logic [1:0] D_STOP = 2'b00;
  localparam logic [1:0] D_CW   = 2'b01;
  localparam logic [1:0] D_CCW  = 2'b10;

  typedef struct {
    logic [1:0] dir;
    logic       lim;
    int         len;
    int         busy_total;
  } exp_t;

  logic             CLK;
  logic             RST;
  logic             adc_valid;
  logic             adc_ch;
  logic [ADC_W-1:0] adc_data;
  logic [31:0]      servo_position;
  logic             BTN_0;
  logic             BTN_1;
  logic             at_limit;
  logic             busy;
  logic [2:0]       state_dbg;

  int   vectors;
  int   miscompares;
  exp_t exp_q[$];

  light_tracker_fsm #(
    .ADC_W      (ADC_W),
    .DEADBAND   (DEADBAND),
    .MOVE_CYC   (MOVE_CYC),
    .SETTLE_CYC (SETTLE_CYC),
    .POS_MIN    (POS_MIN),
    .POS_MAX    (POS_MAX)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .adc_valid      (adc_valid),
    .adc_ch         (adc_ch),
    .adc_data       (adc_data),
    .servo_position (servo_position),
    .BTN_0          (BTN_0),
    .BTN_1          (BTN_1),
    .at_limit       (at_limit),
    .busy           (busy),
    .state_dbg      (state_dbg)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Independent decision model working on plain integers.
  function automatic exp_t model(input int l, input int r, input int pos);
    exp_t e;
    int   d;
    d = l - r;
    e.dir = D_STOP;
    e.lim = 1'b0;
    e.len = 0;
    e.busy_total = 1;
    if (d > DEADBAND) begin
      if (pos < POS_MAX) begin
        e.dir = D_CW;
        e.len = MOVE_CYC;
        e.busy_total = 1 + MOVE_CYC + SETTLE_CYC;
      end else begin
        e.lim = 1'b1;
      end
    end else if (d < -DEADBAND) begin
      if (pos > POS_MIN) begin
        e.dir = D_CCW;
        e.len = MOVE_CYC;
        e.busy_total = 1 + MOVE_CYC + SETTLE_CYC;
      end else begin
        e.lim = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_sample(input logic ch, input int val);
    adc_valid = 1'b1;
    adc_ch    = ch;
    adc_data  = ADC_W'(val);
    tick();
    adc_valid = 1'b0;
  endtask

  // Drives one left/right pair; in the averaging build each value is sent
  // four times so the average equals the value itself.
  task automatic applyStimulus(input int l, input int r, input int pos);
    int reps;
`ifdef TRACK_AVG_EN
    reps = 4;
`else
    reps = 1;
`endif
    servo_position = 32'(pos);
    exp_q.push_back(model(l, r, pos));
    for (int i = 0; i < reps; i++) send_sample(1'b0, l);
    for (int i = 0; i < reps; i++) send_sample(1'b1, r);
  endtask

  // Called just after the edge that captured the last sample.
  task automatic observe_decision(input string name);
    exp_t e;
    int   n0, n1, nbusy, guard;
    bit   overlap;
    tick();
    vectors++;
    if (state_dbg !== 3'd1) begin
      miscompares++;
      $display("[TB] FAIL %s compare_state: got %0d want 1", name, state_dbg);
    end
    tick();
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s scoreboard: got empty queue want an entry", name);
      return;
    end
    e = exp_q.pop_front();
    vectors++;
    if ({BTN_1, BTN_0} !== e.dir) begin
      miscompares++;
      $display("[TB] FAIL %s first_btn: got %b want %b", name, {BTN_1, BTN_0}, e.dir);
    end
    vectors++;
    if (at_limit !== e.lim) begin
      miscompares++;
      $display("[TB] FAIL %s at_limit: got %b want %b", name, at_limit, e.lim);
    end
    n0 = 0; n1 = 0; nbusy = 1; guard = 0; overlap = 1'b0;
    while (busy === 1'b1 && guard < 500) begin
      if (BTN_0 === 1'b1) n0++;
      if (BTN_1 === 1'b1) n1++;
      if (BTN_0 === 1'b1 && BTN_1 === 1'b1) overlap = 1'b1;
      nbusy++;
      guard++;
      tick();
    end
    vectors++;
    if (guard >= 500) begin
      miscompares++;
      $display("[TB] FAIL %s busy_timeout: got %0d cycles want < 500", name, guard);
    end
    vectors++;
    if (n0 != ((e.dir == D_CW) ? e.len : 0) || n1 != ((e.dir == D_CCW) ? e.len : 0)) begin
      miscompares++;
      $display("[TB] FAIL %s pulse_len: got cw=%0d ccw=%0d want dir=%b len=%0d", name, n0, n1, e.dir, e.len);
    end
    vectors++;
    if (nbusy != e.busy_total) begin
      miscompares++;
      $display("[TB] FAIL %s busy_cycles: got %0d want %0d", name, nbusy, e.busy_total);
    end
    vectors++;
    if (overlap !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s btn_overlap: got 1 want 0", name);
    end
    vectors++;
    if (state_dbg !== 3'd0 || at_limit !== e.lim) begin
      miscompares++;
      $display("[TB] FAIL %s end_state: got st=%0d lim=%b want st=0 lim=%b", name, state_dbg, at_limit, e.lim);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick(); tick(); tick();
    vectors++;
    if ({BTN_0, BTN_1, at_limit, busy, state_dbg} !== 7'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %b want 0000000", {BTN_0, BTN_1, at_limit, busy, state_dbg});
    end
    RST = 1'b0;
    tick();
    vectors++;
    if (state_dbg !== 3'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_release: got st=%0d busy=%b want st=0 busy=0", state_dbg, busy);
    end
  endtask

  task automatic test_moves();
    applyStimulus(2000, 1800, 1500);
    observe_decision("cw_move");
    applyStimulus(1000, 1400, 1500);
    observe_decision("ccw_move");
  endtask

  task automatic test_deadband();
    applyStimulus(1000, 1064, 1500);
    observe_decision("db_minus64");
    applyStimulus(1064, 1000, 1500);
    observe_decision("db_plus64");
    applyStimulus(1065, 1000, 1500);
    observe_decision("db_plus65");
  endtask

  task automatic test_limits();
    applyStimulus(500, 900, 500);
    observe_decision("ccw_blocked");
    applyStimulus(500, 900, 1500);
    observe_decision("ccw_clear");
    applyStimulus(2000, 1800, 2500);
    observe_decision("cw_blocked");
    applyStimulus(2000, 1800, 2499);
    observe_decision("cw_below_max");
  endtask

`ifndef TRACK_AVG_EN
  task automatic test_overwrite();
    servo_position = 32'd1500;
    exp_q.push_back(model(2000, 1800, 1500));
    send_sample(1'b0, 100);
    send_sample(1'b0, 2000);
    send_sample(1'b1, 1800);
    observe_decision("overwrite");
  endtask
`endif

  task automatic test_abort();
    int n0, ns, guard;
    applyStimulus(2000, 1800, 1500);
    void'(exp_q.pop_back());
    tick(); tick();
    n0 = 0;
    for (int i = 1; i <= 4; i++) begin
      if (BTN_0 === 1'b1) n0++;
      if (i == 4) servo_position = 32'd2500;
      tick();
    end
    vectors++;
    if (n0 != 4 || BTN_0 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_btn: got high=%0d now=%b want high=4 now=0", n0, BTN_0);
    end
    vectors++;
    if (state_dbg !== 3'd4 || at_limit !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL abort_state: got st=%0d lim=%b want st=4 lim=1", state_dbg, at_limit);
    end
    ns = 0; guard = 0;
    while (busy === 1'b1 && guard < 500) begin
      ns++;
      guard++;
      tick();
    end
    vectors++;
    if (ns != SETTLE_CYC) begin
      miscompares++;
      $display("[TB] FAIL abort_settle: got %0d want %0d", ns, SETTLE_CYC);
    end
    servo_position = 32'd1500;
  endtask

  task automatic test_ignore_strobes();
    int guard;
    bit leaked;
    applyStimulus(2000, 1800, 1500);
    void'(exp_q.pop_back());
    tick(); tick();
    send_sample(1'b0, 0);
    send_sample(1'b1, 4000);
    for (int i = 0; i < 10; i++) tick();
    send_sample(1'b0, 100);
    send_sample(1'b1, 3000);
    guard = 0;
    while (busy === 1'b1 && guard < 500) begin
      guard++;
      tick();
    end
    leaked = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (state_dbg !== 3'd0 || busy !== 1'b0) leaked = 1'b1;
      tick();
    end
    vectors++;
    if (leaked !== 1'b0 || guard >= 500) begin
      miscompares++;
      $display("[TB] FAIL ignore_idle: got leaked=%b guard=%0d want leaked=0 guard<500", leaked, guard);
    end
    applyStimulus(1000, 1200, 1500);
    observe_decision("post_settle");
  endtask

  task automatic test_reset_mid_move();
    applyStimulus(2000, 1800, 1500);
    void'(exp_q.pop_back());
    tick(); tick();
    tick(); tick(); tick(); tick();
    vectors++;
    if (BTN_0 !== 1'b1 || state_dbg !== 3'd2) begin
      miscompares++;
      $display("[TB] FAIL midmove_pre: got btn0=%b st=%0d want btn0=1 st=2", BTN_0, state_dbg);
    end
    RST = 1'b1;
    tick();
    vectors++;
    if (BTN_0 !== 1'b0 || BTN_1 !== 1'b0 || state_dbg !== 3'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midmove_reset: got btn=%b%b st=%0d busy=%b want 00 st=0 busy=0",
               BTN_1, BTN_0, state_dbg, busy);
    end
    RST = 1'b0;
    tick();
    applyStimulus(1800, 2000, 1500);
    observe_decision("after_reset");
  endtask

`ifdef TRACK_AVG_EN
  task automatic test_average();
    servo_position = 32'd1500;
    send_sample(1'b0, 100);
    send_sample(1'b0, 200);
    send_sample(1'b0, 300);
    send_sample(1'b1, 0);
    send_sample(1'b1, 0);
    send_sample(1'b1, 0);
    send_sample(1'b0, 400);
    tick(); tick();
    vectors++;
    if (state_dbg !== 3'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL avg_early: got st=%0d busy=%b want st=0 busy=0", state_dbg, busy);
    end
    exp_q.push_back(model(250, 0, 1500));
    send_sample(1'b1, 0);
    observe_decision("average");
  endtask
`endif

  initial begin
    vectors        = 0;
    miscompares    = 0;
    RST            = 1'b1;
    adc_valid      = 1'b0;
    adc_ch         = 1'b0;
    adc_data       = '0;
    servo_position = 32'd1500;
    test_reset();
    test_moves();
    test_deadband();
    test_limits();
`ifndef TRACK_AVG_EN
    test_overwrite();
`endif
    test_abort();
    test_ignore_strobes();
    test_reset_mid_move();
`ifdef TRACK_AVG_EN
    test_average();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
